// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MD_UNIT_MADD_EN to enable the madd/maddu accumulate ops (8, 9).
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MD_UNIT_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MADDU = 4'd9;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic               w_multi, w_single, w_div, w_accept;
    logic [2*WIDTH-1:0] w_ps, w_pu;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_uq, w_ur, w_qs, w_rs, w_q, w_r;

    always_comb begin
        w_multi  = 1'b0;
        w_single = 1'b0;
        w_div    = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: w_multi = 1'b1;
            OP_DIV, OP_DIVU: begin
                w_multi = 1'b1;
                w_div   = 1'b1;
            end
            OP_MTHI, OP_MTLO:  w_single = 1'b1;
            OP_MADD, OP_MADDU: w_multi = MADD_EN;
            default: ;
        endcase
    end

    assign busy     = (r_state == RUN);
    assign w_accept = (r_state == IDLE) && !flush;
    assign stall    = busy | ((w_multi | w_single) & ~flush);
    assign hi       = r_hi;
    assign lo       = r_lo;

    // Sign-extended operands make the low 2*WIDTH bits the signed product.
    assign w_ps = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_pu = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Signed divide via magnitudes; most-negative / -1 wraps to itself.
    assign w_a_neg = r_a[WIDTH-1];
    assign w_b_neg = r_b[WIDTH-1];
    assign w_abs_a = w_a_neg ? -r_a : r_a;
    assign w_abs_b = w_b_neg ? -r_b : r_b;
    assign w_uq    = w_abs_a / w_abs_b;
    assign w_ur    = w_abs_a % w_abs_b;
    assign w_qs    = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
    assign w_rs    = w_a_neg ? -w_ur : w_ur;
    assign w_q     = r_a / r_b;
    assign w_r     = r_a % r_b;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_multi) w_next = RUN;
            RUN:     if (r_cnt == '0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (r_state == IDLE) begin
            if (w_accept && w_multi) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_cnt <= w_div ? DIV_LD : MULT_LD;
            end
            if (w_accept && op == OP_MTHI) r_hi <= a;
            if (w_accept && op == OP_MTLO) r_lo <= a;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end else begin
            case (r_op)
                OP_MULT:  {r_hi, r_lo} <= w_ps;
                OP_MULTU: {r_hi, r_lo} <= w_pu;
                OP_MADD:  {r_hi, r_lo} <= {r_hi, r_lo} + w_ps;
                OP_MADDU: {r_hi, r_lo} <= {r_hi, r_lo} + w_pu;
                OP_DIV: if (r_b != '0) begin
                    r_lo <= w_qs;
                    r_hi <= w_rs;
                end
                OP_DIVU: if (r_b != '0) begin
                    r_lo <= w_q;
                    r_hi <= w_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL declare parameter WIDTH, default 32, operand and HI/LO register width in bits (minimum 8).
REQ-002 SHALL declare parameter MULT_CYCLES, default 5, busy duration of multiply operations (minimum 1).
REQ-003 SHALL declare parameter DIV_CYCLES, default 10, busy duration of divide operations (minimum 1).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port op, input, 4 bits: operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 read (no state effect), 8 madd, 9 maddu.
REQ-008 SHALL have port a, input, WIDTH bits: rs operand.
REQ-009 SHALL have port b, input, WIDTH bits: rt operand.
REQ-010 SHALL have port flush, input, 1 bit: the current op is cancelled (exception or eret).
REQ-011 SHALL have port busy, output, 1 bit: registered; a multi-cycle operation is in flight.
REQ-012 SHALL have port stall, output, 1 bit: combinational; busy OR (op in 1..9 excluding 7, and flush low).
REQ-013 SHALL have port hi, output, WIDTH bits: HI register.
REQ-014 SHALL have port lo, output, WIDTH bits: LO register.

Function
REQ-015 SHALL accept an op at a rising edge only when busy=0 and flush=0; otherwise op is ignored with no state change.
REQ-016 SHALL, on accepting op 1/2/8/9, latch operands, load the counter, and hold busy=1 for exactly MULT_CYCLES cycles starting the next cycle.
REQ-017 SHALL, on accepting op 3/4, do the same with DIV_CYCLES.
REQ-018 SHALL write the result into hi/lo at the same edge that drops busy; hi/lo SHALL hold their old values while busy=1.
REQ-019 SHALL, for mult, set {hi,lo} to the signed 2*WIDTH product; for multu, to the unsigned 2*WIDTH product.
REQ-020 SHALL, for div, set lo to the signed quotient truncated toward zero and hi to the remainder carrying the dividend's sign; for divu, use unsigned quotient and remainder.
REQ-021 SHALL, for a divide with b=0, leave hi and lo unchanged after the full DIV_CYCLES busy period.
REQ-022 SHALL, for signed divide of the most-negative value by -1, set lo to the most-negative value and hi to 0.
REQ-023 SHALL, on accepting mthi (5) or mtlo (6), write a into hi or lo at that same edge, with busy staying 0.
REQ-024 SHALL operate its state machine with two states, IDLE and RUN.
  - IDLE to RUN on accept of ops 1-4, 8 or 9.
  - RUN to IDLE when the counter reaches its final cycle.
  - No other transitions.
REQ-025 SHALL let flush that arrives after acceptance leave the in-flight op unaffected; the op SHALL complete normally.
REQ-026 SHALL be able to accept a new op at the edge where busy falls, provided stall allowed it (busy must be 0 when sampled).

Reset
REQ-027 SHALL, while reset=1 at an edge:
  - set hi=0, lo=0, busy=0, state IDLE and counter 0;
  - abort any in-flight op with no result written;
  - take priority over every op input.

Configuration
REQ-028 SHALL provide macro MD_UNIT_MADD_EN: when defined, op 8 (madd) and op 9 (maddu) add the signed or unsigned 2*WIDTH product to {hi,lo}, modulo 2^(2*WIDTH), with MULT_CYCLES latency.
REQ-029 SHALL, when MD_UNIT_MADD_EN is undefined, treat ops 8 and 9 as op 0: not accepted, no stall contribution, no state change.

Verification
REQ-030 SHALL cover signed multiply: WIDTH=32, mult a=0xFFFFFFFD b=4 leads to busy high for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFF4.
REQ-031 SHALL cover unsigned multiply: multu a=0xFFFFFFFF b=2 leads to hi=0x00000001 and lo=0xFFFFFFFE after 5 cycles.
REQ-032 SHALL cover signed divide: div a=0xFFFFFFF9 (-7) b=2 leads to busy high for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-033 SHALL cover divide by zero and ops while busy:
  - preload hi=0x11 and lo=0x22 via mthi/mtlo;
  - divu a=7 b=0, with mtlo a=0x55 issued on busy cycle 3;
  - required: hi=0x11 and lo=0x22 after 10 cycles, and the mtlo is ignored.
REQ-034 SHALL cover flush and reset:
  - mult with flush=1 gives busy=0 and hi/lo unchanged;
  - reset asserted on busy cycle 2 gives hi=lo=0 and busy=0 at the next edge.
REQ-035 SHALL cover the macro:
  - with MD_UNIT_MADD_EN, hi=0, lo=0xFFFFFFFF, then maddu a=1 b=1 gives hi=1 and lo=0;
  - without the macro, the same op gives stall=0 and no change.
